// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: FSM states, shift direction
// encoding and datapath widths.
package shift_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the
// shared shift arbiter. The arbiter uses the slave modport.
interface shift_arbiter_if import shift_arbiter_pkg::*; #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ*AMT_W-1:0]  req_amt;
    logic [NREQ-1:0]        req_lr;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_W-1:0]      rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_data, req_amt, req_lr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_lr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/shift16_core.sv
// Combinational 16-bit logarithmic shifter: four stages of 1, 2, 4 and 8
// bits, zero fill in both directions.
module shift16_core import shift_arbiter_pkg::*; (
    input  logic [DATA_W-1:0] din,
    input  logic [AMT_W-1:0]  amt,
    input  logic              lr,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] stage1_s;
    logic [DATA_W-1:0] stage2_s;
    logic [DATA_W-1:0] stage4_s;
    logic [DATA_W-1:0] stage8_s;

    // Each stage shifts by its power of two when the matching amount bit is set.
    always_comb begin
        stage1_s = din;
        stage2_s = din;
        stage4_s = din;
        stage8_s = din;

        if (amt[0]) begin
            stage1_s = (lr == DIR_LEFT) ? {din[14:0], 1'b0} : {1'b0, din[15:1]};
        end else begin
            stage1_s = din;
        end

        if (amt[1]) begin
            stage2_s = (lr == DIR_LEFT) ? {stage1_s[13:0], 2'b00} : {2'b00, stage1_s[15:2]};
        end else begin
            stage2_s = stage1_s;
        end

        if (amt[2]) begin
            stage4_s = (lr == DIR_LEFT) ? {stage2_s[11:0], 4'h0} : {4'h0, stage2_s[15:4]};
        end else begin
            stage4_s = stage2_s;
        end

        if (amt[3]) begin
            stage8_s = (lr == DIR_LEFT) ? {stage4_s[7:0], 8'h00} : {8'h00, stage4_s[15:8]};
        end else begin
            stage8_s = stage4_s;
        end
    end

    assign dout = stage8_s;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit shifter between NREQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (shift) -> RESP (hold result).
module shift_arbiter import shift_arbiter_pkg::*; #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);
    state_t              state_r;
    logic [IDW-1:0]      last_grant_r;
    logic [DATA_W-1:0]   op_data_r;
    logic [AMT_W-1:0]    op_amt_r;
    logic                op_lr_r;
    logic [IDW-1:0]      op_id_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic [IDW-1:0]      rsp_id_r;
    logic                busy_r;

    logic [NREQ-1:0]     grant_s;
    logic [IDW-1:0]      win_id_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [AMT_W-1:0]    sel_amt_s;
    logic                sel_lr_s;
    logic [DATA_W-1:0]   shift_out_s;

    // Round-robin pick: priority distance of requester j is how far it sits
    // after the last winner; the valid requester with the smallest distance wins.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                 input logic [IDW-1:0]  last);
        logic [NREQ-1:0] grant;
        logic            found;
        logic            hit;
        grant = {NREQ{1'b0}};
        found = 1'b0;
        for (int d = 0; d < NREQ; d++) begin
            for (int j = 0; j < NREQ; j++) begin
                hit      = valid[j] & ~found &
                           (((j - int'(last) - 1 + 2 * NREQ) % NREQ) == d);
                grant[j] = grant[j] | hit;
                found    = found | hit;
            end
        end
        return grant;
    endfunction

    assign grant_s = rr_pick(bus.req_valid, last_grant_r);

    // Encode the one-hot winner and mux its operands; unused ids stay zero.
    always_comb begin
        win_id_s   = {IDW{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        sel_amt_s  = {AMT_W{1'b0}};
        sel_lr_s   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            win_id_s   = win_id_s   | (grant_s[j] ? IDW'(j) : {IDW{1'b0}});
            sel_data_s = sel_data_s | (grant_s[j] ? bus.req_data[DATA_W*j +: DATA_W] : {DATA_W{1'b0}});
            sel_amt_s  = sel_amt_s  | (grant_s[j] ? bus.req_amt[AMT_W*j +: AMT_W]    : {AMT_W{1'b0}});
            sel_lr_s   = sel_lr_s   | (grant_s[j] & bus.req_lr[j]);
        end
    end

    shift16_core u_core (
        .din  (op_data_r),
        .amt  (op_amt_r),
        .lr   (op_lr_r),
        .dout (shift_out_s)
    );

    // Control FSM: grant and capture in IDLE, register the shift in EXEC,
    // hold the response in RESP until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= IDW'(NREQ - 1);
            op_data_r    <= {DATA_W{1'b0}};
            op_amt_r     <= {AMT_W{1'b0}};
            op_lr_r      <= 1'b0;
            op_id_r      <= {IDW{1'b0}};
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {DATA_W{1'b0}};
            rsp_id_r     <= {IDW{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|grant_s) begin
                        state_r      <= ST_EXEC;
                        busy_r       <= 1'b1;
                        op_data_r    <= sel_data_s;
                        op_amt_r     <= sel_amt_s;
                        op_lr_r      <= sel_lr_s;
                        op_id_r      <= win_id_s;
                        last_grant_r <= win_id_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= shift_out_s;
                    rsp_id_r    <= op_id_r;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_r == ST_IDLE) ? grant_s : {NREQ{1'b0}};
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_shift_arbiter;
    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic clk;
    logic rst_n;

    shift_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    bit          m_inflight;
    bit          m_resp;
    int          m_last;
    logic [15:0] m_op_data;
    logic [3:0]  m_op_amt;
    bit          m_op_lr;
    int          m_op_id;
    logic [15:0] m_rsp_data;
    int          m_rsp_id;

    bit accepted;
    int acc_id;
    int acc_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a, input bit lr);
        int v;
        v = int'(d);
        if (lr) v = (v << a) & 32'h0000FFFF;
        else    v = v >> a;
        return v[15:0];
    endfunction

    // Winner by the round-robin rule, or -1 when nothing can be granted.
    function automatic int model_pick();
        int idx;
        if (m_inflight) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (bus.req_valid[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_inflight = 0;
        m_resp     = 0;
        m_last     = NREQ - 1;
        m_rsp_data = 16'h0000;
        m_rsp_id   = 0;
    endtask

    task automatic raise(input int i, input logic [15:0] d, input logic [3:0] a, input bit lr);
        bus.req_valid[i]        = 1'b1;
        bus.req_data[16*i +: 16] = d;
        bus.req_amt[4*i +: 4]    = a;
        bus.req_lr[i]            = lr;
    endtask

    task automatic raise_rand(input int i);
        if (bus.req_valid[i] !== 1'b1)
            raise(i, 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    // One clock: check the grant, advance the model on the edge, then check outputs.
    task automatic step();
        int p;
        logic [NREQ-1:0] exp_rdy;
        #1;
        p = model_pick();
        exp_rdy = '0;
        if (p >= 0) exp_rdy[p] = 1'b1;
        check_val("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        accepted = 0;
        @(posedge clk);
        cyc++;
        if (m_resp) begin
            if (bus.rsp_ready) begin
                m_resp = 0;
                m_inflight = 0;
            end
        end else if (m_inflight) begin
            m_resp     = 1;
            m_rsp_data = ref_shift(m_op_data, m_op_amt, m_op_lr);
            m_rsp_id   = m_op_id;
        end else if (p >= 0) begin
            m_op_data  = bus.req_data[16*p +: 16];
            m_op_amt   = bus.req_amt[4*p +: 4];
            m_op_lr    = bus.req_lr[p];
            m_op_id    = p;
            m_last     = p;
            m_inflight = 1;
            accepted   = 1;
            acc_id     = p;
            acc_cyc    = cyc;
        end
        @(negedge clk);
        if (accepted) bus.req_valid[acc_id] = 1'b0;
        check_val("rsp_valid", 32'(bus.rsp_valid), 32'(m_resp));
        check_val("busy", 32'(bus.busy), 32'(m_inflight));
        if (m_resp) begin
            check_val("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
            check_val("rsp_id", 32'(bus.rsp_id), 32'(m_rsp_id));
        end
    endtask

    task automatic do_op(input int id, input logic [15:0] d, input logic [3:0] a, input bit lr,
                         input logic [15:0] exp);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        onehot[id] = 1'b1;
        bus.rsp_ready = 1'b1;
        raise(id, d, a, lr);
        #1 check_val("op_grant", 32'(bus.req_ready), 32'(onehot));
        step();
        step();
        check_val("op_valid", 32'(bus.rsp_valid), 32'd1);
        check_val("op_data", 32'(bus.rsp_data), 32'(exp));
        check_val("op_id", 32'(bus.rsp_id), 32'(id));
        step();
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
    endtask

    int ids[$];
    int cycs[$];

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_lr    = '0;
        bus.rsp_ready = 1'b0;
        model_reset();

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check_val("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;

        // 1: first grant goes to r0, result two cycles after accept
        raise(0, 16'h00F1, 4'd4, 1'b1);
        #1 check_val("t1_grant", 32'(bus.req_ready), 32'b001);
        step();
        check_val("t1_not_yet", 32'(bus.rsp_valid), 32'd0);
        step();
        check_val("t1_valid", 32'(bus.rsp_valid), 32'd1);
        check_val("t1_data", 32'(bus.rsp_data), 32'h0F10);
        check_val("t1_id", 32'(bus.rsp_id), 32'd0);
        bus.rsp_ready = 1'b1;
        step();

        // 2: right shift by 15 and zero-amount passthrough
        do_op(1, 16'h8000, 4'd15, 1'b0, 16'h0001);
        do_op(0, 16'h1234, 4'd0, 1'b1, 16'h1234);
        do_op(1, 16'hA5C3, 4'd0, 1'b0, 16'hA5C3);

        // 3: r0 and r1 continuously valid -> alternate, 3 cycles apart
        bus.rsp_ready = 1'b1;
        ids.delete();
        cycs.delete();
        for (int k = 0; k < 12; k++) begin
            raise_rand(0);
            raise_rand(1);
            step();
            if (accepted) begin
                ids.push_back(acc_id);
                cycs.push_back(acc_cyc);
            end
        end
        check_val("t3_count", 32'(ids.size()), 32'd4);
        for (int k = 0; k < ids.size() && k < 4; k++) begin
            check_val("t3_order", 32'(ids[k]), 32'(k % 2));
            if (k > 0) check_val("t3_interval", 32'(cycs[k] - cycs[k-1]), 32'd3);
        end
        drain();

        // 4: response stalled for 5 cycles
        bus.rsp_ready = 1'b0;
        raise(0, 16'hABCD, 4'd3, 1'b0);
        step();
        step();
        raise(1, 16'h0F0F, 4'd8, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("t4_valid", 32'(bus.rsp_valid), 32'd1);
            check_val("t4_data", 32'(bus.rsp_data), 32'h1579);
            check_val("t4_id", 32'(bus.rsp_id), 32'd0);
            check_val("t4_ready0", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        #1 check_val("t4_next_grant", 32'(bus.req_ready), 32'b010);
        step();
        step();
        step();
        check_val("t4_r1_data", 32'(bus.rsp_data), 32'h0F00);
        drain();

        // 5: sole r2, then all three valid -> order 0,1,2
        raise(2, 16'h0003, 4'd1, 1'b1);
        #1 check_val("t5_sole", 32'(bus.req_ready), 32'b100);
        step();
        step();
        check_val("t5_data", 32'(bus.rsp_data), 32'h0006);
        check_val("t5_id", 32'(bus.rsp_id), 32'd2);
        step();
        ids.delete();
        for (int i = 0; i < NREQ; i++) raise_rand(i);
        for (int k = 0; k < 9; k++) begin
            step();
            if (accepted) ids.push_back(acc_id);
        end
        check_val("t5_count", 32'(ids.size()), 32'd3);
        for (int k = 0; k < ids.size() && k < 3; k++)
            check_val("t5_order", 32'(ids[k]), 32'(k));
        drain();

        // 6: reset during EXEC discards the op
        raise(1, 16'h00FF, 4'd4, 1'b1);
        step();
        check_val("t6_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_val("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("t6_rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) raise_rand(i);
        #1 check_val("t6_first_r0", 32'(bus.req_ready), 32'b001);
        step();
        drain();

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 2) == 0) raise_rand(i);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 16-bit combinational barrel shifter between NREQ requesters.
- Round-robin arbitration; the winner's operands are captured, shifted and registered.
- The result is returned on a single valid/ready response channel tagged with the requester id.
- Sits between ALU-side requesters and the shared shift datapath; at most one operation is in flight.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the response id field; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_data  in  NREQ*16  operand; requester i uses bits [16i+15:16i].
- req_amt  in  NREQ*4  shift amount 0..15; requester i uses bits [4i+3:4i].
- req_lr  in  NREQ  direction: 1 = left, 0 = right.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  16  shifted result.
- rsp_id  out  IDW  index of the requester that issued the operation.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; last_grant=NREQ-1, so requester 0 has first priority.
  - All operand registers 0; rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, busy=0.
- States:
  - IDLE -> EXEC when any req_valid=1.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready=1; otherwise stay in RESP and hold everything.
- Arbitration (IDLE only):
  - Search order starts at (last_grant+1) mod NREQ and ascends with wrap.
  - The first requester with req_valid=1 wins.
  - req_ready is combinational: one-hot on the winner in IDLE, 0 in every other state.
- Transfer rule: the handshake completes when req_valid&req_ready. On that edge:
  - capture data, amt, lr and id into operand registers;
  - update last_grant to the winner.
- Requester rules:
  - A requester must hold valid and its operands stable until accepted.
  - Non-winners see req_ready=0 and keep waiting.
- EXEC cycle:
  - The shifter sub-module computes from the operand registers.
  - The result is registered into rsp_data and rsp_id; rsp_valid is set on the EXEC->RESP edge.
- Shift semantics:
  - left: out = (in << amt) mod 2^16, zero fill.
  - right: out = in >> amt, logical, zero fill.
  - amt=0 passes the operand unchanged.
- Response channel:
  - rsp_valid, rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid clears on the edge where rsp_valid&rsp_ready.
- Latency and throughput:
  - Accept in cycle N; rsp_valid=1 in cycle N+2.
  - Minimum issue interval is 3 cycles, because a new grant is only possible in the cycle after the response is accepted.
- Boundary conditions:
  - Simultaneous requests: exactly one grant per IDLE cycle, per the round-robin order.
  - A sole requester is granted every IDLE cycle regardless of last_grant.
  - req_valid deasserted in IDLE: no grant, state unchanged.
  - rsp_ready held high: RESP lasts exactly one cycle.
  - rsp_ready=1 outside RESP is ignored.
  - req_valid for requester index >= NREQ does not exist; no X propagation from unused id bits (pad with 0).
  - Reset mid-operation: the in-flight op is discarded, no response is produced, and the state returns to IDLE immediately.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - DIR_LEFT=1'b1, DIR_RIGHT=1'b0;
  - data width 16 and amount width 4.
- One sub-module, shift16_core: purely combinational 4-stage log shifter (stages of 1, 2, 4 and 8 bits) with the semantics above. It is instantiated once.
- The round-robin picker stays inline as a function.

Test Plan:
1. Reset released, r0: data=16'h00F1, amt=4, lr=1:
   - req_ready=01 in the same cycle;
   - rsp_valid=1 two cycles later with rsp_data=16'h0F10, rsp_id=0.
2. r1: data=16'h8000, amt=15, lr=0 -> rsp_data=16'h0001, rsp_id=1.
   - Then amt=0 with lr either value -> rsp_data equals the operand.
3. Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each issue is 3 cycles apart; ids match the grants.
4. rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant; req_ready=00 throughout.
   - rsp_ready=1 -> the next grant occurs in the following cycle.
5. NREQ=3: only r2 valid -> granted; then all valid -> order 0,1,2.
6. rst_n pulsed low during EXEC -> rsp_valid=0 with no response emitted, state IDLE, and requester 0 is granted first afterwards.
